// File: rtl/alu_cmd_assembler.sv
// ---------------------------------------------------------------------------
// alu_cmd_assembler
//
// Upstream stage of the ALU. Parses the UART byte stream for frames of the
// form HEADER, OPCODE, A, B, CHK (CHK = OPCODE ^ A ^ B). It then presents the
// committed operands and operation select to the ALU through a valid/ready
// handshake.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous, active-high reset
//   rx_data      received byte from the UART receiver
//   rx_valid     one-cycle strobe, rx_data valid this cycle
//   cmd_ready    ALU accepts the pending command
//   A, B         committed operands
//   ALUSel       committed operation select
//   cmd_valid    command pending on A/B/ALUSel
//   busy         parser is not idle
//   err_op       one-cycle pulse: opcode byte has bits [7:3] set
//   err_chk      one-cycle pulse: checksum mismatch
//   err_timeout  one-cycle pulse: inter-byte gap too long inside a frame
//   err_overrun  one-cycle pulse: byte arrived while a command was pending
// ---------------------------------------------------------------------------
module alu_cmd_assembler #(
  parameter logic [7:0]  HEADER         = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 50000  // must be >= 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       cmd_ready,
  output logic [7:0] A,
  output logic [7:0] B,
  output logic [2:0] ALUSel,
  output logic       cmd_valid,
  output logic       busy,
  output logic       err_op,
  output logic       err_chk,
  output logic       err_timeout,
  output logic       err_overrun
);

  localparam int unsigned   CW      = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] TC_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GET_OP,
    S_GET_A,
    S_GET_B,
    S_GET_CHK,
    S_PEND
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_op_sh;
  logic [7:0]    r_a_sh;
  logic [7:0]    r_b_sh;
  logic [7:0]    r_a;
  logic [7:0]    r_b;
  logic [2:0]    r_alusel;
  logic          r_cmd_valid;
  logic          r_busy;
  logic          r_err_op;
  logic          r_err_chk;
  logic          r_err_timeout;
  logic          r_err_overrun;

  logic          w_chk_ok;
  logic          w_tc;

  assign w_chk_ok = (rx_data == ({5'b0, r_op_sh} ^ r_a_sh ^ r_b_sh));
  assign w_tc     = (r_cnt == TC_LAST);

  // NOTE: every register here is state, so it is written with non-blocking
  // assignments only; this keeps the order of updates within the block
  // irrelevant and matches what the flops do at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_op_sh       <= '0;
      r_a_sh        <= '0;
      r_b_sh        <= '0;
      r_a           <= '0;
      r_b           <= '0;
      r_alusel      <= '0;
      r_cmd_valid   <= 1'b0;
      r_busy        <= 1'b0;
      r_err_op      <= 1'b0;
      r_err_chk     <= 1'b0;
      r_err_timeout <= 1'b0;
      r_err_overrun <= 1'b0;
    end else begin
      // Error flags are one-cycle pulses unless re-raised below.
      r_err_op      <= 1'b0;
      r_err_chk     <= 1'b0;
      r_err_timeout <= 1'b0;
      r_err_overrun <= 1'b0;

      case (r_state)
        S_IDLE: begin
          // Non-header bytes between frames are dropped without comment.
          if (rx_valid && rx_data == HEADER) begin
            r_state <= S_GET_OP;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
          end
        end

        S_GET_OP, S_GET_A, S_GET_B, S_GET_CHK: begin
          if (rx_valid) begin
            // A byte on the terminal-count cycle still wins over the timeout.
            r_cnt <= '0;
            case (r_state)
              S_GET_OP: begin
                if (|rx_data[7:3]) begin
                  r_err_op <= 1'b1;
                  r_state  <= S_IDLE;
                  r_busy   <= 1'b0;
                end else begin
                  r_op_sh <= rx_data[2:0];
                  r_state <= S_GET_A;
                end
              end
              S_GET_A: begin
                r_a_sh  <= rx_data;
                r_state <= S_GET_B;
              end
              S_GET_B: begin
                r_b_sh  <= rx_data;
                r_state <= S_GET_CHK;
              end
              default: begin  // S_GET_CHK
                if (w_chk_ok) begin
                  r_a         <= r_a_sh;
                  r_b         <= r_b_sh;
                  r_alusel    <= r_op_sh;
                  r_cmd_valid <= 1'b1;
                  r_state     <= S_PEND;
                end else begin
                  r_err_chk <= 1'b1;
                  r_state   <= S_IDLE;
                  r_busy    <= 1'b0;
                end
              end
            endcase
          end else if (w_tc) begin
            // Abandon the partial frame; the shadows are cleared so nothing
            // from it can leak into a later commit.
            r_err_timeout <= 1'b1;
            r_state       <= S_IDLE;
            r_busy        <= 1'b0;
            r_cnt         <= '0;
            r_op_sh       <= '0;
            r_a_sh        <= '0;
            r_b_sh        <= '0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end

        S_PEND: begin
          // Bytes cannot be buffered while a command is outstanding.
          if (rx_valid) begin
            r_err_overrun <= 1'b1;
          end
          if (cmd_ready) begin
            r_cmd_valid <= 1'b0;
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign A           = r_a;
  assign B           = r_b;
  assign ALUSel      = r_alusel;
  assign cmd_valid   = r_cmd_valid;
  assign busy        = r_busy;
  assign err_op      = r_err_op;
  assign err_chk     = r_err_chk;
  assign err_timeout = r_err_timeout;
  assign err_overrun = r_err_overrun;

endmodule
